// File: rtl/frogger_input_ctrl.sv
// ---------------------------------------------------------------------------
// frogger_input_ctrl
//
// Sits between the four debounce filters and the game core. It turns
// debounced button levels into clean one-cycle command pulses:
//   - a single held button gives one move pulse, then auto-repeat pulses
//     after REPEAT_DELAY cycles and every REPEAT_PERIOD cycles after that;
//   - all four buttons held for START_HOLD cycles give one start pulse;
//   - any multi-button press is a chord attempt and never moves the frog.
// At most one of the five pulse outputs is high in any cycle. All outputs
// are registered.
//
// Parameters
//   REPEAT_DELAY  : cycles from the first move pulse to the first repeat (>=2)
//   REPEAT_PERIOD : cycles between successive repeat pulses (>=2)
//   START_HOLD    : cycles all four buttons must be held for a start (>=2)
//
// Ports
//   i_Clk                       system clock
//   i_Reset                     asynchronous, active-high reset
//   i_Up/i_Down/i_Left/i_Right  debounced button levels, active high
//   i_Enable                    game running; gates move pulses only
//   o_Up/Down/Left/Right_Pulse  one-cycle move commands
//   o_Start_Pulse               one-cycle start command
//   o_Dir                       last commanded direction
//                               (0=Up, 1=Down, 2=Left, 3=Right)
//   o_Busy                      high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module frogger_input_ctrl #(
  parameter int REPEAT_DELAY  = 12500000,
  parameter int REPEAT_PERIOD = 6250000,
  parameter int START_HOLD    = 25000000
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Up,
  input  logic       i_Down,
  input  logic       i_Left,
  input  logic       i_Right,
  input  logic       i_Enable,
  output logic       o_Up_Pulse,
  output logic       o_Down_Pulse,
  output logic       o_Left_Pulse,
  output logic       o_Right_Pulse,
  output logic       o_Start_Pulse,
  output logic [1:0] o_Dir,
  output logic       o_Busy
);

  // One counter is shared by every timed state, so it is sized for the
  // largest of the three terminal counts.
  localparam int MAX_RD = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int MAX_P  = (MAX_RD > START_HOLD) ? MAX_RD : START_HOLD;
  localparam int CW     = $clog2(MAX_P);

  localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] START_LAST  = CW'(START_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRESSED  = 3'd1,
    S_REPEAT   = 3'd2,
    S_CHORD    = 3'd3,
    S_WAIT_REL = 3'd4
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [3:0]      move_q;    // bit index == direction code
  logic            start_q;
  logic [1:0]      dir_q;
  logic            busy_q;

  // -------------------------------------------------------------------------
  // Button vector, ordered so that the bit index equals the direction code.
  // -------------------------------------------------------------------------
  logic [3:0] btn;
  assign btn = {i_Right, i_Left, i_Down, i_Up};

  // Number of buttons held this cycle, and the index of a held button
  // (only meaningful when exactly one is held).
  logic [2:0] n_held;
  logic [1:0] held_dir;

  always_comb begin
    n_held   = 3'd0;
    held_dir = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (btn[i]) begin
        n_held   = n_held + 3'd1;
        held_dir = 2'(i);
      end
    end
  end

  logic none_held;
  logic one_held;
  logic multi_held;
  logic all_held;

  assign none_held  = (n_held == 3'd0);
  assign one_held   = (n_held == 3'd1);
  assign multi_held = (n_held >= 3'd2);
  assign all_held   = (n_held == 3'd4);

  // One-hot decodes of the currently held direction and the latched one,
  // used directly as the next value of the move-pulse register.
  logic [3:0] held_sel;
  logic [3:0] lat_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dir_dec
    assign held_sel[gi] = (held_dir == 2'(gi));
    assign lat_sel[gi]  = (dir_q == 2'(gi));
  end

  // PRESSED and REPEAT share all logic except their terminal count.
  logic [CW-1:0] rpt_last;
  assign rpt_last = (state_q == S_PRESSED) ? DELAY_LAST : PERIOD_LAST;

  // In PRESSED/REPEAT, a held set that is not exactly the latched button
  // means the player is forming a chord (or switched buttons): abandon the
  // move sequence without a pulse.
  logic leave_for_chord;
  assign leave_for_chord = multi_held || (held_dir != dir_q);

  // -------------------------------------------------------------------------
  // Control FSM. Pulses default low every cycle so each is exactly one
  // cycle wide; i_Enable only masks the move pulse, never the state change.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      move_q  <= 4'd0;
      start_q <= 1'b0;
      dir_q   <= 2'd0;
      busy_q  <= 1'b0;
    end else begin
      move_q  <= 4'd0;
      start_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (one_held) begin
            dir_q   <= held_dir;
            move_q  <= i_Enable ? held_sel : 4'd0;
            cnt_q   <= '0;
            state_q <= S_PRESSED;
            busy_q  <= 1'b1;
          end else if (multi_held) begin
            // Simultaneous press: chord attempt, no move pulse.
            cnt_q   <= '0;
            state_q <= S_CHORD;
            busy_q  <= 1'b1;
          end
        end

        S_PRESSED, S_REPEAT: begin
          if (none_held) begin
            // Release beats a terminal count landing in the same cycle.
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (leave_for_chord) begin
            cnt_q   <= '0;
            state_q <= S_CHORD;
          end else if (cnt_q == rpt_last) begin
            move_q  <= i_Enable ? lat_sel : 4'd0;
            cnt_q   <= '0;
            state_q <= S_REPEAT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        S_CHORD: begin
          if (none_held) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (all_held) begin
            if (cnt_q == START_LAST) begin
              start_q <= 1'b1;
              state_q <= S_WAIT_REL;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end else begin
            // Partial chord: the hold must restart from scratch.
            cnt_q <= '0;
          end
        end

        S_WAIT_REL: begin
          // Anything still held after a chord is ignored until full release.
          if (none_held) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_Up_Pulse    = move_q[0];
  assign o_Down_Pulse  = move_q[1];
  assign o_Left_Pulse  = move_q[2];
  assign o_Right_Pulse = move_q[3];
  assign o_Start_Pulse = start_q;
  assign o_Dir         = dir_q;
  assign o_Busy        = busy_q;

endmodule

// File: tb/tb_frogger_input_ctrl.sv
// ---------------------------------------------------------------------------
// tb_frogger_input_ctrl
//
// Drives frogger_input_ctrl (REPEAT_DELAY=4, REPEAT_PERIOD=2, START_HOLD=8)
// with directed scenarios followed by random button segments, and compares
// every output each cycle against a timing model written in terms of
// "edges since press" and "edges since all four held".
// ---------------------------------------------------------------------------
module tb_frogger_input_ctrl;

  localparam int TD = 4;  // REPEAT_DELAY
  localparam int TP = 2;  // REPEAT_PERIOD
  localparam int TH = 8;  // START_HOLD

  logic       clk;
  logic       rst;
  logic [3:0] btn;        // {Right, Left, Down, Up}
  logic       en;
  logic       up_p, dn_p, lf_p, rt_p, st_p, busy;
  logic [1:0] dir;

  frogger_input_ctrl #(
    .REPEAT_DELAY (TD),
    .REPEAT_PERIOD(TP),
    .START_HOLD   (TH)
  ) dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .i_Up         (btn[0]),
    .i_Down       (btn[1]),
    .i_Left       (btn[2]),
    .i_Right      (btn[3]),
    .i_Enable     (en),
    .o_Up_Pulse   (up_p),
    .o_Down_Pulse (dn_p),
    .o_Left_Pulse (lf_p),
    .o_Right_Pulse(rt_p),
    .o_Start_Pulse(st_p),
    .o_Dir        (dir),
    .o_Busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 single button held, 2 chord attempt, 3 waiting release
  int         m_mode = 0;
  int         m_edge = 0;
  int         m_press_edge = 0;
  int         m_four_since = -1;
  logic [1:0] m_dir = 2'd0;
  logic [3:0] e_moves = 4'd0;
  logic       e_start = 1'b0;

  function automatic int popcnt(input logic [3:0] b);
    int c = 0;
    for (int i = 0; i < 4; i++) if (b[i]) c++;
    return c;
  endfunction

  function automatic logic [1:0] first_idx(input logic [3:0] b);
    logic [1:0] r = 2'd0;
    for (int i = 0; i < 4; i++) if (b[i]) r = 2'(i);
    return r;
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_dir   = 2'd0;
    e_moves = 4'd0;
    e_start = 1'b0;
    m_four_since = -1;
  endtask

  // Expected outputs for the cycle after an edge that sampled (b, en_v).
  task automatic model_edge(input logic [3:0] b, input logic en_v);
    int n;
    int el;
    logic [1:0] idx;
    n = popcnt(b);
    idx = first_idx(b);
    e_moves = 4'd0;
    e_start = 1'b0;
    case (m_mode)
      0: begin
        if (n == 1) begin
          m_dir = idx;
          m_mode = 1;
          m_press_edge = m_edge;
          if (en_v) e_moves[idx] = 1'b1;
        end else if (n >= 2) begin
          m_mode = 2;
          m_four_since = -1;
        end
      end
      1: begin
        if (n == 0) m_mode = 0;
        else if (n >= 2 || idx != m_dir) begin
          m_mode = 2;
          m_four_since = -1;
        end else begin
          el = m_edge - m_press_edge;
          if (el >= TD && ((el - TD) % TP) == 0 && en_v) e_moves[m_dir] = 1'b1;
        end
      end
      2: begin
        if (n == 0) m_mode = 0;
        else if (n == 4) begin
          if (m_four_since < 0) m_four_since = m_edge;
          if (m_edge - m_four_since == TH - 1) begin
            e_start = 1'b1;
            m_mode = 3;
          end
        end else m_four_since = -1;
      end
      default: begin
        if (n == 0) m_mode = 0;
      end
    endcase
    m_edge++;
  endtask

  // ---------------- stimulus helpers ----------------
  int mv_cnt [4];
  int st_cnt;

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) mv_cnt[i] = 0;
    st_cnt = 0;
  endtask

  task automatic compare_outputs();
    check("moves", {28'd0, rt_p, lf_p, dn_p, up_p}, {28'd0, e_moves});
    check("start", {31'd0, st_p}, {31'd0, e_start});
    check("dir",   {30'd0, dir},  {30'd0, m_dir});
    check("busy",  {31'd0, busy}, {31'd0, (m_mode != 0)});
    mv_cnt[0] += int'(up_p);
    mv_cnt[1] += int'(dn_p);
    mv_cnt[2] += int'(lf_p);
    mv_cnt[3] += int'(rt_p);
    st_cnt    += int'(st_p);
  endtask

  // Inputs change 1 time unit after the edge; outputs are read at the same
  // point, well away from the next active edge.
  task automatic step(input logic [3:0] b, input logic en_v);
    btn = b;
    en  = en_v;
    @(posedge clk);
    model_edge(b, en_v);
    #1;
    compare_outputs();
  endtask

  task automatic hold(input logic [3:0] b, input logic en_v, input int cycles);
    for (int i = 0; i < cycles; i++) step(b, en_v);
  endtask

  task automatic pulse_reset(input int cycles);
    rst = 1'b1;
    #1;
    model_reset();
    compare_outputs();
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      compare_outputs();
    end
    rst = 1'b0;
  endtask

  logic [3:0] pat;
  logic       en_r;
  int         len;
  int         r;
  int         a_i;
  int         b_i;

  initial begin
    rst = 1'b1;
    btn = 4'd0;
    en  = 1'b0;
    model_reset();
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    compare_outputs();
    rst = 1'b0;

    // Tap Up for 3 cycles.
    hold(4'd0, 1'b1, 2);
    clear_counts();
    hold(4'b0001, 1'b1, 3);
    hold(4'd0, 1'b1, 3);
    check("tap_up_count", mv_cnt[0], 1);
    $display("scenario tap_up: up_pulses=%0d", mv_cnt[0]);

    // Hold Right for 12 cycles: pulses at t=1,5,7,9,11.
    clear_counts();
    hold(4'b1000, 1'b1, 12);
    check("hold_right_count", mv_cnt[3], 5);
    hold(4'd0, 1'b1, 2);
    $display("scenario hold_right: right_pulses=%0d", mv_cnt[3]);

    // Four-button chord for 10 cycles, then release three of them.
    clear_counts();
    hold(4'b1111, 1'b1, 10);
    hold(4'b0001, 1'b1, 3);
    check("chord_start_count", st_cnt, 1);
    check("chord_move_count", mv_cnt[0] + mv_cnt[1] + mv_cnt[2] + mv_cnt[3], 0);
    hold(4'd0, 1'b1, 2);
    $display("scenario chord: starts=%0d", st_cnt);

    // Chord with Left dropped for one cycle.
    clear_counts();
    hold(4'b1111, 1'b1, 5);
    hold(4'b1011, 1'b1, 1);
    hold(4'b1111, 1'b1, 8);
    check("chord_drop_start_count", st_cnt, 1);
    hold(4'd0, 1'b1, 2);
    $display("scenario chord_drop: starts=%0d", st_cnt);

    // Down held while disabled, then enabled.
    clear_counts();
    hold(4'b0010, 1'b0, 6);
    check("disabled_down_count", mv_cnt[1], 0);
    hold(4'b0010, 1'b1, 4);
    check("enabled_down_count", mv_cnt[1], 2);
    hold(4'd0, 1'b1, 2);
    $display("scenario enable_gate: down_pulses=%0d", mv_cnt[1]);

    // Reset during REPEAT with Left held.
    hold(4'b0100, 1'b1, 7);
    pulse_reset(2);
    clear_counts();
    hold(4'b0100, 1'b1, 6);
    check("post_reset_left_count", mv_cnt[2], 2);
    hold(4'd0, 1'b1, 2);
    $display("scenario reset_repeat: left_pulses=%0d", mv_cnt[2]);

    // Random segments.
    for (int s = 0; s < 250; s++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        len = $urandom_range(1, 3);
        pulse_reset(len);
        $display("seg %0d reset len=%0d", s, len);
      end else begin
        r = $urandom_range(0, 9);
        len = $urandom_range(1, 12);
        if (r <= 4) begin
          pat = 4'd0;
          pat[$urandom_range(0, 3)] = 1'b1;
        end else if (r == 5) begin
          pat = 4'd0;
        end else if (r == 6 || r == 9) begin
          pat = 4'b1111;
          len = $urandom_range(1, 14);
        end else if (r == 7) begin
          a_i = $urandom_range(0, 3);
          b_i = (a_i + $urandom_range(1, 3)) % 4;
          pat = 4'd0;
          pat[a_i] = 1'b1;
          pat[b_i] = 1'b1;
        end else begin
          pat = 4'($urandom_range(0, 15));
        end
        en_r = ($urandom_range(0, 4) != 0);
        hold(pat, en_r, len);
        $display("seg %0d btn=%b en=%0d len=%0d", s, pat, en_r, len);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/frogger_input_ctrl.md
# frogger_input_ctrl

Input conditioner between the four debounce filters and the game core. It turns debounced switch levels into single-cycle movement command pulses, with hold-to-repeat. It also detects the four-button "hold to start" chord and emits one start pulse for it. Downstream logic sees clean, mutually exclusive one-cycle events instead of raw levels.

## Interface
- `REPEAT_DELAY`, 12500000: cycles from first move pulse to first auto-repeat pulse; ≥2.
- `REPEAT_PERIOD`, 6250000: cycles between successive auto-repeat pulses; ≥2.
- `START_HOLD`, 25000000: cycles all four buttons must be held to emit a start; ≥2.
- `i_Clk`  in  1  system clock.
- `i_Reset`  in  1  asynchronous, active-high reset.
- `i_Up`, `i_Down`, `i_Left`, `i_Right`  in  1 each  debounced button levels, active high.
- `i_Enable`  in  1  game running; gates move pulses only.
- `o_Up_Pulse`, `o_Down_Pulse`, `o_Left_Pulse`, `o_Right_Pulse`  out  1 each  one-cycle move commands.
- `o_Start_Pulse`  out  1  one-cycle start command.
- `o_Dir`  out  2  last commanded direction: 0=Up, 1=Down, 2=Left, 3=Right.
- `o_Busy`  out  1  high whenever state ≠ IDLE.

## Operation
- Reset state:
  - FSM in IDLE, counter 0.
  - All pulses 0, `o_Dir`=0, `o_Busy`=0.
- One shared counter, width `$clog2` of the largest parameter.
- `n` is the number of buttons high in the current cycle.
- States and transitions:
  - **IDLE**
    - n=1: latch that direction into `o_Dir`, issue a move pulse, counter←0, go to PRESSED.
    - n≥2: counter←0, go to CHORD.
    - n=0: stay.
  - **PRESSED**
    - n=0: go to IDLE.
    - n≥2, or the single held button differs from the latched one: counter←0, go to CHORD, no pulse.
    - Otherwise: counter increments. At counter=REPEAT_DELAY−1, issue a move pulse, counter←0, go to REPEAT.
  - **REPEAT**
    - Same exits as PRESSED.
    - Otherwise: at counter=REPEAT_PERIOD−1, issue a move pulse, counter←0, stay.
  - **CHORD**
    - n=0: go to IDLE.
    - All four held: counter increments. At counter=START_HOLD−1, assert `o_Start_Pulse`, go to WAIT_REL.
    - 1≤n≤3: counter←0, stay. Dropping a button resets the hold.
  - **WAIT_REL**
    - Stay until n=0, then go to IDLE. No pulses are issued here.
- Move pulses:
  - The pulse for the latched direction is asserted only if `i_Enable`=1 in the issuing cycle.
  - If `i_Enable`=0, the FSM still advances exactly as if the pulse had been issued.
- `o_Start_Pulse` ignores `i_Enable`.
- At most one of the five pulse outputs is high in any cycle.
- `o_Dir` updates only on entry from IDLE and holds otherwise.
- Returning from CHORD to IDLE requires full release. A button still held after a chord never produces a move pulse.

## Timing
- All outputs are registered.
- A state decision at edge k produces a pulse high for exactly the cycle after edge k+1.
- First move pulse: button rises before edge k, pulse high in cycle k+1. Latency is 1 cycle.
- First repeat pulse: exactly REPEAT_DELAY cycles after the first pulse.
- Subsequent repeats: every REPEAT_PERIOD cycles.
- Start pulse: exactly START_HOLD cycles after the first cycle all four buttons are seen in CHORD. If the chord is formed from IDLE in one cycle, count START_HOLD from CHORD entry plus one.
- Simultaneous press of two buttons in the same cycle from IDLE goes to CHORD with no move pulse.
- Release and repeat terminal count in the same cycle: release wins, no pulse.
- `i_Reset` asserted mid-operation:
  - Outputs clear immediately (asynchronous).
  - After deassertion the FSM is in IDLE.
  - A button still held at deassertion counts as a new press (pulse next cycle).

## Test plan
Parameters for all scenarios: REPEAT_DELAY=4, REPEAT_PERIOD=2, START_HOLD=8.
- Tap Up for 3 cycles, `i_Enable`=1 → exactly one `o_Up_Pulse`, 1 cycle after the rise; `o_Dir`=0; `o_Busy` falls 1 cycle after release.
- Hold Right for 12 cycles → `o_Right_Pulse` at t=1, 5, 7, 9, 11; `o_Dir`=3.
- Press all four in one cycle and hold 10 cycles → `o_Start_Pulse` only at t=9, no move pulses. Releasing 3 of them leaves the FSM in WAIT_REL until the last is released.
- Hold all four for 5 cycles, drop Left for 1 cycle, hold 8 more → no start before the drop; start 8 cycles after all four return.
- Hold Down with `i_Enable`=0 for 6 cycles, then set `i_Enable`=1 → no pulses while disabled; next `o_Down_Pulse` lands on the REPEAT_PERIOD grid established from press time.
- Assert `i_Reset` during REPEAT with Left held, for 2 cycles → all outputs 0 while reset is high; `o_Left_Pulse` 1 cycle after deassertion, then repeats from the new timebase.
